hw_config_regs: RTL and testbench
=================================

Name: hw_config_regs

Overview:
Parametrised successor to the static hardware-config constants. Memory-mapped, read-mostly register bank on the IO bus. Reports RAM size, device mask and CPU info, and adds live timing registers: a cycle counter with a coherent 64-bit snapshot, a microsecond uptime counter, and a scratch word. Sits beside the other IO devices and is selected by the IO address decoder.

Parameters:
RAM_BYTES, 32'd6144, available RAM in bytes, reported at word 0
DEVICES, 32'd0, configured-device bitmask, reported at word 1
FREQ_MHZ, 16'd60, core clock in MHz; also the microsecond prescaler divisor; must be >= 1
COUNTER_WIDTH, 32, cycle counter width; legal range 1..64
BUILD_ID, 32'h0000_0000, build identifier, reported at word 7

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sel  in  1  block selected by the IO decoder
rd  in  1  read strobe, one cycle, qualified by sel
wr  in  1  write strobe, one cycle, qualified by sel
addr  in  3  word index
wdata  in  32  write data
wmask  in  4  byte write enables
rdata  out  32  read data, registered
rvalid  out  1  one-cycle pulse marking rdata as valid

Behaviour:
- Reset: one clock (clk) and one reset (reset); reset is synchronous and active-high. On reset: cycle counter, high shadow, microsecond counter, prescaler, scratch, rdata and rvalid are all 0.
- Register map (word index):
  - 0 RAM_BYTES (RO)
  - 1 DEVICES (RO)
  - 2 {FREQ_MHZ[15:0], COUNTER_WIDTH[15:0]} (RO)
  - 3 cycle counter bits 31:0 (R; write clears)
  - 4 high shadow, cycle counter bits 63:32 (RO)
  - 5 microsecond counter (R; write clears)
  - 6 scratch (RW, byte-masked)
  - 7 BUILD_ID (RO)
- Writes to RO words are ignored.
- Cycle counter:
  - Increments by 1 every cycle and wraps mod 2^COUNTER_WIDTH.
  - Bits at or above COUNTER_WIDTH read as 0.
  - When COUNTER_WIDTH <= 32, word 4 always reads 0.
- Snapshot:
  - A read of word 3 returns counter[31:0] as it stands in the rd cycle.
  - In the same cycle, counter[63:32] is latched into the high shadow.
  - A later read of word 4 returns the shadow, so the low/high pair is coherent across a carry.
  - The shadow changes only on word-3 reads and on reset.
- Microsecond counter:
  - Prescaler counts FREQ_MHZ-1 down to 0, then reloads.
  - On the reload cycle the 32-bit microsecond counter increments; it wraps at 2^32.
  - FREQ_MHZ = 1 means the counter increments every cycle.
- Clear priority: a write to word 3 sets the counter to 0 in that cycle, and clear wins over increment. The next cycle reads 1. A write to word 5 clears both the microsecond counter and the prescaler (prescaler reloads to FREQ_MHZ-1).
- Scratch: byte i is updated when wmask[i] is set; all other bytes keep their value.
- Read latency: rdata is registered one cycle after sel&rd; rvalid pulses for that same cycle. rdata holds its value until the next read. No wait states.
- Simultaneous rd and wr to the same word: the read returns the pre-write value and the write takes effect.
- Strobes without sel: no effect.
- Reset mid-operation: reset overrides everything. A read issued in the reset cycle produces no rvalid.

Decomposition:
- Package hw_config_pkg holds:
  - word-index localparams (HWC_RAM=0 … HWC_BUILD=7)
  - the cpuinfo packing function {freq, width}
  - COUNTER_WIDTH range-check constants
- Sub-module hw_config_prescaler: parametrised divide-by-FREQ_MHZ tick generator with synchronous clear; emits a one-cycle tick.
- Top level holds the cycle counter, shadow, scratch, decode and read register.

Test Plan:
- Reset, then read words 0/1/2/7 with RAM_BYTES=6144, FREQ_MHZ=60, COUNTER_WIDTH=32 -> 0x1800, DEVICES, 0x003C0020, BUILD_ID; each rvalid arrives exactly 1 cycle after rd.
- COUNTER_WIDTH=64: force the counter to 0x0000_0000_FFFF_FFFE, read word 3, wait 5 cycles, read word 4 -> 0xFFFFFFFE then 0x00000000 (coherent pair, no torn carry).
- COUNTER_WIDTH=8: run 300 cycles after reset, read word 3 -> 300 mod 256 = 44 (±read-cycle offset checked exactly); word 4 -> 0.
- FREQ_MHZ=4: clear via write to word 5, wait 40 cycles, read word 5 -> 10; repeat with FREQ_MHZ=1 -> 40.
- Scratch: write 0xDEADBEEF with wmask=4'hF, then 0x00001200 with wmask=4'b0010 -> read 0xDEAD12EF; writes to word 0 leave it at 0x1800.
- Reset asserted for 1 cycle mid-run, coincident with a wr clear and a rd -> no rvalid; counters, scratch and rdata are 0; the next cycle count reads 1 cycle after deassertion as expected.

Source files
------------

// File: rtl/hw_config_pkg.sv
// rtl/hw_config_pkg.sv - shared constants and helpers for the hardware config register bank
//
// Purpose: word-index map of the register bank, legal cycle-counter width
// range, and the packing helper for the CPU-info word.

package hw_config_pkg;

    // Word indices on the 3-bit address
    localparam logic [2:0] HWC_RAM     = 3'd0;
    localparam logic [2:0] HWC_DEV     = 3'd1;
    localparam logic [2:0] HWC_CPU     = 3'd2;
    localparam logic [2:0] HWC_CYC_LO  = 3'd3;
    localparam logic [2:0] HWC_CYC_HI  = 3'd4;
    localparam logic [2:0] HWC_USEC    = 3'd5;
    localparam logic [2:0] HWC_SCRATCH = 3'd6;
    localparam logic [2:0] HWC_BUILD   = 3'd7;

    // Legal range of the cycle counter width
    localparam int HWC_CW_MIN = 1;
    localparam int HWC_CW_MAX = 64;

    // CPU-info word: clock frequency in the upper half, counter width in the lower
    function automatic logic [31:0] hwc_cpuinfo(input logic [15:0] freq,
                                                input logic [15:0] width);
        return {freq, width};
    endfunction

endpackage

// File: rtl/hw_config_prescaler.sv
// rtl/hw_config_prescaler.sv - divide-by-DIVISOR tick generator with synchronous clear
//
// Purpose: down-counter that runs DIVISOR-1 .. 0 and reloads; o_tick is high
// for the single cycle in which the count is 0 (the reload cycle).
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset (count forced to 0)
//   i_clear  synchronous clear, reloads the count to DIVISOR-1
//   o_tick   one-cycle pulse every DIVISOR cycles

module hw_config_prescaler #(
    parameter logic [15:0] DIVISOR = 16'd60
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [15:0] RELOAD = DIVISOR - 16'd1;

    logic [15:0] r_count;
    logic        w_zero;

    assign w_zero = (r_count == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 16'd0;
        end else if (i_clear || w_zero) begin
            r_count <= RELOAD;
        end else begin
            r_count <= r_count - 16'd1;
        end
    end

    // With DIVISOR == 1 the reload value is 0, so the tick is permanently high.
    assign o_tick = w_zero;

endmodule

// File: rtl/hw_config_regs.sv
// rtl/hw_config_regs.sv - read-mostly hardware configuration and timing register bank
//
// Purpose: IO-bus register bank reporting RAM size, device mask, CPU info and
// build id, plus a free-running cycle counter with coherent high-word
// snapshot, a microsecond uptime counter and a byte-maskable scratch word.
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset
//   sel     block select from the IO decoder
//   rd      one-cycle read strobe (qualified by sel)
//   wr      one-cycle write strobe (qualified by sel)
//   addr    word index 0..7
//   wdata   write data
//   wmask   byte write enables
//   rdata   registered read data, held until the next read
//   rvalid  one-cycle pulse, rdata valid

module hw_config_regs
    import hw_config_pkg::*;
#(
    parameter logic [31:0] RAM_BYTES     = 32'd6144,
    parameter logic [31:0] DEVICES       = 32'd0,
    parameter logic [15:0] FREQ_MHZ      = 16'd60,
    parameter int          COUNTER_WIDTH = 32,
    parameter logic [31:0] BUILD_ID      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic [31:0] rdata,
    output logic        rvalid
);

    if (COUNTER_WIDTH < HWC_CW_MIN || COUNTER_WIDTH > HWC_CW_MAX) begin : g_bad_width
        $error("hw_config_regs: COUNTER_WIDTH out of range 1..64");
    end
    if (FREQ_MHZ == 16'd0) begin : g_bad_freq
        $error("hw_config_regs: FREQ_MHZ must be at least 1");
    end

    localparam logic [15:0]              CW16    = 16'(COUNTER_WIDTH);
    localparam logic [COUNTER_WIDTH-1:0] CYC_ONE = COUNTER_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0] r_cycle;
    logic [31:0]              r_shadow;
    logic [31:0]              r_usec;
    logic [31:0]              r_scratch;
    logic [31:0]              r_rdata;
    logic                     r_rvalid;

    logic [63:0] w_cycle64;
    logic        w_rd;
    logic        w_wr;
    logic        w_clr_cycle;
    logic        w_clr_usec;
    logic        w_wr_scratch;
    logic        w_snap;
    logic        w_tick;
    logic [31:0] w_rd_word;
    logic [31:0] w_scratch_next;

    assign w_rd         = sel & rd;
    assign w_wr         = sel & wr;
    assign w_clr_cycle  = w_wr && (addr == HWC_CYC_LO);
    assign w_clr_usec   = w_wr && (addr == HWC_USEC);
    assign w_wr_scratch = w_wr && (addr == HWC_SCRATCH);
    assign w_snap       = w_rd && (addr == HWC_CYC_LO);

    // Zero-extended view of the counter; bits at or above COUNTER_WIDTH read 0,
    // so for widths <= 32 the shadow only ever captures zeros.
    assign w_cycle64 = 64'(r_cycle);

    hw_config_prescaler #(
        .DIVISOR (FREQ_MHZ)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clr_usec),
        .o_tick  (w_tick)
    );

    // Cycle counter: a clear write takes precedence over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else if (w_clr_cycle) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + CYC_ONE;
        end
    end

    // High shadow is latched with the same counter value that the word-3
    // read returns, so a later word-4 read completes a coherent pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= 32'd0;
        end else if (w_snap) begin
            r_shadow <= w_cycle64[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_usec <= 32'd0;
        end else if (w_clr_usec) begin
            r_usec <= 32'd0;
        end else if (w_tick) begin
            r_usec <= r_usec + 32'd1;
        end
    end

    always_comb begin
        w_scratch_next = r_scratch;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) begin
                w_scratch_next[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scratch <= 32'd0;
        end else if (w_wr_scratch) begin
            r_scratch <= w_scratch_next;
        end
    end

    // Read mux sees pre-write register values, so a simultaneous rd/wr to
    // the same word returns the old contents.
    always_comb begin
        w_rd_word = 32'd0;
        case (addr)
            HWC_RAM:     w_rd_word = RAM_BYTES;
            HWC_DEV:     w_rd_word = DEVICES;
            HWC_CPU:     w_rd_word = hwc_cpuinfo(FREQ_MHZ, CW16);
            HWC_CYC_LO:  w_rd_word = w_cycle64[31:0];
            HWC_CYC_HI:  w_rd_word = r_shadow;
            HWC_USEC:    w_rd_word = r_usec;
            HWC_SCRATCH: w_rd_word = r_scratch;
            HWC_BUILD:   w_rd_word = BUILD_ID;
            default:     w_rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_hw_config_regs.sv
// tb/tb_hw_config_regs.sv - scoreboard bench for the hardware config register bank

module tb_hw_config_regs;

    localparam int          NI        = 5;
    localparam logic [31:0] DEF_DEV   = 32'h0000_00A5;
    localparam logic [31:0] DEF_BUILD = 32'hB01D_2024;

    // instance indices
    localparam int I_DEF = 0;  // width 32, 60 MHz
    localparam int I_W64 = 1;  // width 64
    localparam int I_W8  = 2;  // width 8
    localparam int I_F4  = 3;  // 4 MHz
    localparam int I_F1  = 4;  // 1 MHz

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] s_sel;
    logic          s_rd;
    logic          s_wr;
    logic [2:0]    s_addr;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wmask;
    logic [31:0]   rdata_v [NI];
    logic          rvalid_v [NI];

    int cyc = 0;
    int c0 = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          inst;
        logic [31:0] exp;
        int          due;
        string       name;
    } sb_t;

    sb_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hw_config_regs #(.RAM_BYTES(32'd6144), .DEVICES(DEF_DEV), .FREQ_MHZ(16'd60),
                     .COUNTER_WIDTH(32), .BUILD_ID(DEF_BUILD)) u_def (
        .clk(clk), .reset(reset), .sel(s_sel[I_DEF]), .rd(s_rd), .wr(s_wr),
        .addr(s_addr), .wdata(s_wdata), .wmask(s_wmask),
        .rdata(rdata_v[I_DEF]), .rvalid(rvalid_v[I_DEF]));

    hw_config_regs #(.COUNTER_WIDTH(64)) u_w64 (
        .clk(clk), .reset(reset), .sel(s_sel[I_W64]), .rd(s_rd), .wr(s_wr),
        .addr(s_addr), .wdata(s_wdata), .wmask(s_wmask),
        .rdata(rdata_v[I_W64]), .rvalid(rvalid_v[I_W64]));

    hw_config_regs #(.COUNTER_WIDTH(8)) u_w8 (
        .clk(clk), .reset(reset), .sel(s_sel[I_W8]), .rd(s_rd), .wr(s_wr),
        .addr(s_addr), .wdata(s_wdata), .wmask(s_wmask),
        .rdata(rdata_v[I_W8]), .rvalid(rvalid_v[I_W8]));

    hw_config_regs #(.FREQ_MHZ(16'd4)) u_f4 (
        .clk(clk), .reset(reset), .sel(s_sel[I_F4]), .rd(s_rd), .wr(s_wr),
        .addr(s_addr), .wdata(s_wdata), .wmask(s_wmask),
        .rdata(rdata_v[I_F4]), .rvalid(rvalid_v[I_F4]));

    hw_config_regs #(.FREQ_MHZ(16'd1)) u_f1 (
        .clk(clk), .reset(reset), .sel(s_sel[I_F1]), .rd(s_rd), .wr(s_wr),
        .addr(s_addr), .wdata(s_wdata), .wmask(s_wmask),
        .rdata(rdata_v[I_F1]), .rvalid(rvalid_v[I_F1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        s_sel   = '0;
        s_rd    = 1'b0;
        s_wr    = 1'b0;
        s_addr  = 3'd0;
        s_wdata = 32'd0;
        s_wmask = 4'd0;
    endtask

    // All stimulus tasks are entered at a negedge and return at the next one.
    task automatic do_rd(input int inst, input logic [2:0] a, input logic [31:0] exp,
                         input string nm);
        idle();
        s_sel[inst] = 1'b1;
        s_rd        = 1'b1;
        s_addr      = a;
        sb.push_back('{inst, exp, cyc + 1, nm});
        @(negedge clk);
        idle();
    endtask

    task automatic do_wr(input int inst, input logic [2:0] a, input logic [31:0] d,
                         input logic [3:0] m);
        idle();
        s_sel[inst] = 1'b1;
        s_wr        = 1'b1;
        s_addr      = a;
        s_wdata     = d;
        s_wmask     = m;
        @(negedge clk);
        idle();
    endtask

    task automatic do_rdwr(input int inst, input logic [2:0] a, input logic [31:0] d,
                           input logic [3:0] m, input logic [31:0] exp, input string nm);
        idle();
        s_sel[inst] = 1'b1;
        s_rd        = 1'b1;
        s_wr        = 1'b1;
        s_addr      = a;
        s_wdata     = d;
        s_wmask     = m;
        sb.push_back('{inst, exp, cyc + 1, nm});
        @(negedge clk);
        idle();
    endtask

    // Monitor: pops the scoreboard on every rvalid, checks data, source and latency.
    int  mon_n;
    int  mon_which;
    sb_t mon_e;
    always @(negedge clk) begin
        mon_n     = 0;
        mon_which = 0;
        for (int i = 0; i < NI; i++) begin
            if (rvalid_v[i] === 1'b1) begin
                mon_n++;
                mon_which = i;
            end
        end
        if (mon_n > 1) begin
            chk("multi_rvalid", 64'(mon_n), 64'd1);
        end
        if (mon_n >= 1) begin
            if (sb.size() == 0) begin
                chk("spurious_rvalid", 64'(mon_which), 64'hFFFF);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_data"}, 64'(rdata_v[mon_which]), 64'(mon_e.exp));
                chk({mon_e.name, "_inst"}, 64'(mon_which), 64'(mon_e.inst));
                chk({mon_e.name, "_lat"}, 64'(cyc), 64'(mon_e.due));
            end
        end else if (sb.size() != 0 && cyc > sb[0].due) begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_timeout"}, 64'd0, 64'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_rdata%0d", i), 64'(rdata_v[i]), 64'd0);
            chk($sformatf("rst_rvalid%0d", i), 64'(rvalid_v[i]), 64'd0);
        end
        reset = 1'b0;
        c0 = cyc;

        // constant words
        do_rd(I_DEF, 3'd0, 32'h0000_1800, "ram");
        do_rd(I_DEF, 3'd1, DEF_DEV, "dev");
        do_rd(I_DEF, 3'd2, 32'h003C_0020, "cpuinfo");
        do_rd(I_DEF, 3'd7, DEF_BUILD, "build");
        do_rd(I_DEF, 3'd4, 32'h0, "w32_hi");
        do_rd(I_W8, 3'd2, 32'h003C_0008, "w8_cpuinfo");

        // 8-bit counter wraps: 300 mod 256 = 44
        while (cyc - c0 < 300) @(negedge clk);
        do_rd(I_W8, 3'd3, 32'd44, "w8_lo");
        do_rd(I_W8, 3'd4, 32'd0, "w8_hi");

        // 64-bit coherent snapshot across a low-word carry
        force u_w64.r_cycle = 64'h0000_0000_FFFF_FFFE;
        do_rd(I_W64, 3'd3, 32'hFFFF_FFFE, "w64_lo");
        release u_w64.r_cycle;
        repeat (5) @(negedge clk);
        do_rd(I_W64, 3'd4, 32'h0000_0000, "w64_hi");

        // microsecond counter
        do_wr(I_F4, 3'd5, 32'hFFFF_FFFF, 4'hF);
        repeat (40) @(negedge clk);
        do_rd(I_F4, 3'd5, 32'd10, "usec_f4");
        do_wr(I_F1, 3'd5, 32'h0, 4'hF);
        repeat (40) @(negedge clk);
        do_rd(I_F1, 3'd5, 32'd40, "usec_f1");

        // scratch, RO write, unselected strobes, simultaneous rd/wr
        do_wr(I_DEF, 3'd6, 32'hDEAD_BEEF, 4'hF);
        do_wr(I_DEF, 3'd6, 32'h0000_1200, 4'b0010);
        do_rd(I_DEF, 3'd6, 32'hDEAD_12EF, "scratch_mask");
        do_wr(I_DEF, 3'd0, 32'hFFFF_FFFF, 4'hF);
        do_rd(I_DEF, 3'd0, 32'h0000_1800, "ram_ro");
        s_wr = 1'b1; s_rd = 1'b1; s_addr = 3'd6; s_wdata = 32'h0; s_wmask = 4'hF;
        @(negedge clk);
        idle();
        do_rd(I_DEF, 3'd6, 32'hDEAD_12EF, "nosel");
        do_rdwr(I_DEF, 3'd6, 32'hCAFE_F00D, 4'hF, 32'hDEAD_12EF, "rdwr_old");
        do_rd(I_DEF, 3'd6, 32'hCAFE_F00D, "rdwr_new");

        // cycle clear: read in the write cycle sees the old count
        do_rdwr(I_DEF, 3'd3, 32'h0, 4'hF, 32'(cyc - c0), "clr_old");
        @(negedge clk);
        do_rd(I_DEF, 3'd3, 32'd1, "clr_after");

        // reset mid-run with a coincident clear write and read
        idle();
        reset = 1'b1;
        s_sel[I_DEF] = 1'b1; s_rd = 1'b1; s_wr = 1'b1; s_addr = 3'd3; s_wmask = 4'hF;
        @(negedge clk);
        idle();
        reset = 1'b0;
        c0 = cyc;
        chk("midrst_rdata", 64'(rdata_v[I_DEF]), 64'd0);
        chk("midrst_rvalid", 64'(rvalid_v[I_DEF]), 64'd0);
        do_rd(I_DEF, 3'd5, 32'd0, "midrst_usec");
        do_rd(I_DEF, 3'd3, 32'd1, "midrst_cyc");
        do_rd(I_DEF, 3'd6, 32'd0, "midrst_scratch");
        do_rd(I_DEF, 3'd4, 32'd0, "midrst_hi");

        repeat (3) @(negedge clk);
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_missing"}, 64'd0, 64'd1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
